// File: rtl/mm_stage_unit_if.sv
// rtl/mm_stage_unit_if.sv - data-cache request/response bus between the memory stage and the dcache
interface mm_stage_unit_if #(
    parameter int WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN,
        output dmemWEN,
        output dmemaddr,
        output dmemstore,
        input  dhit,
        input  dmemload
    );

    modport slave (
        input  dmemREN,
        input  dmemWEN,
        input  dmemaddr,
        input  dmemstore,
        output dhit,
        output dmemload
    );
endinterface

// File: rtl/mm_stage_unit.sv
// rtl/mm_stage_unit.sv - memory stage: consumes EX/MEM, drives dcache requests, produces registered MEM/WB
module mm_stage_unit #(
    parameter int TIMEOUT = 1024,
    parameter int WORD_W  = 32,
    parameter int REG_W   = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic              dRENi,
    input  logic              dWENi,
    input  logic [WORD_W-1:0] ALUOut,
    input  logic [WORD_W-1:0] store,
    input  logic [WORD_W-1:0] npc,
    input  logic [REG_W-1:0]  rd,
    input  logic              RegWEN,
    input  logic [1:0]        MemtoReg,
    input  logic              halt,
    input  logic              flush,
    mm_stage_unit_if.master   dmem,
    output logic              mm_stall,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_RegWEN,
    output logic [WORD_W-1:0] wb_data,
    output logic              wb_halt,
    output logic              err
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    logic              ren_q;
    logic              wen_q;
    logic [WORD_W-1:0] h_alu;
    logic [WORD_W-1:0] h_store;
    logic [REG_W-1:0]  h_rd;
    logic              h_regwen;
    logic [1:0]        h_m2r;
    logic [CNT_W-1:0]  wait_cnt;

    assign dmem.dmemREN   = ren_q;
    assign dmem.dmemWEN   = wen_q;
    assign dmem.dmemaddr  = h_alu;
    assign dmem.dmemstore = h_store;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            h_alu     <= '0;
            h_store   <= '0;
            h_rd      <= '0;
            h_regwen  <= 1'b0;
            h_m2r     <= 2'd0;
            wait_cnt  <= '0;
            mm_stall  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_RegWEN <= 1'b0;
            wb_data   <= '0;
            wb_halt   <= 1'b0;
            err       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        // halt takes priority, so a halt-flagged memory op never reaches the cache
                        if (halt) begin
                            wb_valid  <= 1'b1;
                            wb_RegWEN <= 1'b0;
                            wb_halt   <= 1'b1;
                            state     <= HALTED;
                        end else if (dRENi || dWENi) begin
                            h_alu    <= ALUOut;
                            h_store  <= store;
                            h_rd     <= rd;
                            h_regwen <= RegWEN;
                            h_m2r    <= MemtoReg;
                            ren_q    <= !dWENi;
                            wen_q    <= dWENi;
                            mm_stall <= 1'b1;
                            wait_cnt <= '0;
                            state    <= ACCESS;
                        end else begin
                            wb_valid  <= 1'b1;
                            wb_rd     <= rd;
                            wb_RegWEN <= RegWEN;
                            wb_data   <= (MemtoReg == 2'd2) ? npc : ALUOut;
                        end
                    end
                end
                ACCESS: begin
                    // flush is deliberately not looked at here: the access is already committed
                    if (dmem.dhit) begin
                        ren_q     <= 1'b0;
                        wen_q     <= 1'b0;
                        mm_stall  <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= IDLE;
                        wb_valid  <= 1'b1;
                        wb_rd     <= h_rd;
                        wb_RegWEN <= h_regwen;
                        wb_data   <= (!wen_q && h_m2r == 2'd1) ? dmem.dmemload : h_alu;
                    end else if (wait_cnt == CNT_LAST) begin
                        err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HALTED: begin
                    wb_halt <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mm_stage_unit.md
Name: mm_stage_unit

Overview:
- Consumer end of the EX/MEM pipeline register, sitting in the memory stage.
- Accepts one latched EX/MEM instruction per cycle and drives the data-cache request (read/write) until the cache returns a hit.
- Selects the write-back value and presents registered MEM/WB outputs.
- Stalls upstream stages while a data access is outstanding, and tracks halt and access-timeout conditions.

Parameters:
TIMEOUT, 1024, cycles in ACCESS without dhit before err is set (sticky)
WORD_W, 32, data/address width (word_t)
REG_W, 5, register index width (regbits_t)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
in_valid  in  1  EX/MEM register holds a valid instruction
dRENi  in  1  instruction is a load
dWENi  in  1  instruction is a store
ALUOut  in  32  effective address / ALU result
store  in  32  store data
npc  in  32  PC+4, used for link write-back
rd  in  5  destination register
RegWEN  in  1  instruction writes a register
MemtoReg  in  2  write-back select: 0 = ALU, 1 = MEM, 2 = NPC, 3 = ALU
halt  in  1  halt instruction
flush  in  1  discard the current EX/MEM input
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  32  cache address
dmemstore  out  32  cache write data
dhit  in  1  cache completes the request this cycle
dmemload  in  32  load data, valid when dhit
mm_stall  out  1  upstream must hold the EX/MEM contents
wb_valid  out  1  MEM/WB outputs carry a retired instruction (1-cycle pulse)
wb_rd  out  5  write-back register
wb_RegWEN  out  1  write-back enable, qualified by wb_valid
wb_data  out  32  write-back value
wb_halt  out  1  sticky halt
err  out  1  sticky timeout error

Behaviour:
- States: IDLE, ACCESS, HALTED. Reset state is IDLE.
- Reset values: all outputs 0; hold registers 0; wait counter 0.
- Accept condition in IDLE: in_valid & !flush.
  - flush & in_valid in IDLE: input dropped, no wb_valid, no state change.
- Non-memory op (dRENi = 0, dWENi = 0) accepted in IDLE:
  - Next cycle: wb_valid = 1, wb_rd = rd, wb_RegWEN = RegWEN.
  - wb_data = npc if MemtoReg = 2, else ALUOut.
  - Latency 1, no stall.
- Memory op accepted in IDLE:
  - Capture ALUOut, store, rd, RegWEN, MemtoReg and load/store type into hold registers.
  - Go to ACCESS.
- ACCESS:
  - dmemREN or dmemWEN (from hold type), dmemaddr = held ALUOut, dmemstore = held store; all stable every cycle.
  - mm_stall = 1 for every ACCESS cycle, including the dhit cycle.
  - Request signals are 0 in every state other than ACCESS.
- dhit in ACCESS:
  - Next cycle: state IDLE, wb_valid = 1.
  - Load: wb_data = dmemload sampled at dhit, if held MemtoReg = 1.
  - Store: wb_RegWEN = held RegWEN (0 by decode); wb_data = held ALUOut.
  - A new input is accepted no earlier than the cycle after dhit.
- dhit seen in IDLE or HALTED: ignored.
- dRENi & dWENi both 1: treated as a store; no read is issued.
- flush while in ACCESS: ignored. The access is committed and completes normally.
- Timeout:
  - Wait counter increments each ACCESS cycle without dhit and clears on leaving ACCESS.
  - Counter reaching TIMEOUT-1 without dhit sets err (sticky until RST); the access continues.
  - Counter saturates and does not wrap.
- halt & accepted in IDLE:
  - Next cycle: wb_valid = 1 with wb_RegWEN = 0, wb_halt = 1, state HALTED.
  - HALTED accepts nothing and holds wb_halt = 1 until RST; mm_stall = 0.
  - A memory op flagged halt: treated as halt only, no access issued.
- wb_valid is a single-cycle pulse per retired instruction. wb_rd, wb_data and wb_RegWEN hold their last values when wb_valid = 0.
- RST mid-ACCESS: next cycle state IDLE, dmemREN = dmemWEN = 0, mm_stall = 0, no wb_valid for the aborted instruction.

Test Plan:
- ALU op: in_valid = 1, ALUOut = 0x0000_00A5, rd = 3, RegWEN = 1, MemtoReg = 0 -> next cycle wb_valid = 1, wb_rd = 3, wb_data = 0xA5, mm_stall never asserted.
- Load with 2-cycle miss: dRENi = 1, ALUOut = 0x100, rd = 7, MemtoReg = 1; dhit in the 3rd ACCESS cycle with dmemload = 0xDEADBEEF -> dmemREN = 1 and dmemaddr = 0x100 for 3 cycles, mm_stall high 3 cycles, then wb_valid = 1, wb_rd = 7, wb_data = 0xDEADBEEF.
- Store: dWENi = 1, ALUOut = 0x200, store = 0x1234; dhit first ACCESS cycle -> dmemWEN = 1, dmemstore = 0x1234 for 1 cycle, then wb_valid = 1 with wb_RegWEN = 0.
- JAL and flush: MemtoReg = 2, npc = 0x44 -> wb_data = 0x44. Then the same input with flush = 1 -> no wb_valid. Flush asserted during ACCESS -> access still completes.
- Halt: halt = 1 -> wb_halt = 1 next cycle and remains 1 after further in_valid inputs; RST clears it to 0.
- Timeout and reset: TIMEOUT = 8, load with no dhit -> err = 1 after the 8th ACCESS cycle. Then RST = 1 -> dmemREN = 0, err = 0, state IDLE next cycle.
